// File: rtl/peripheral_pkg.sv
// Shared definitions for the peripheral datapath counters and timers.
// Direction/mode encodings and the load clamp helper live here.
package peripheral_pkg;

   typedef enum logic {
      DIR_DN = 1'b0,
      DIR_UP = 1'b1
   } dir_e;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   // Operands are WIDTH+1 bits at most (WIDTH <= 32), so 33 bits covers every instance.
   function automatic logic [32:0] clamp(input logic [32:0] val, input logic [32:0] max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate mode,
// registered terminal-count pulse and sticky overflow flag.
module mod_counter
   import peripheral_pkg::*;
#(
   parameter int unsigned      WIDTH   = 20,
   parameter longint unsigned  MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
   input  logic             clk,
   input  logic             sclr_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   if ((WIDTH < 1) || (WIDTH > 32) || (MAX_VAL > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_params
      $fatal(1, "mod_counter: WIDTH must be 1..32 and MAX_VAL <= 2**WIDTH-1");
   end

   localparam logic [WIDTH:0] MAXW = (WIDTH + 1)'(MAX_VAL);
   localparam logic [WIDTH:0] ONE  = (WIDTH + 1)'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   q_ext;
   logic             bnd;

   always_comb begin
      q_d   = q_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
      bnd   = 1'b0;
      q_ext = {1'b0, q_q};

      if (clr) begin
         q_d   = '0;
         ovf_d = 1'b0;
      end else begin
         if (load) begin
            q_d = WIDTH'(clamp(33'(load_val), 33'(MAXW)));
         end else if (en) begin
            bnd = (up_dn == DIR_UP) ? (q_ext == MAXW) : (q_ext == '0);
            if (bnd) begin
               if (sat == MODE_WRAP) begin
                  q_d = (up_dn == DIR_UP) ? '0 : WIDTH'(MAXW);
               end
            end else begin
               q_d = (up_dn == DIR_UP) ? WIDTH'(q_ext + ONE) : WIDTH'(q_ext - ONE);
            end
         end
         // A boundary event in the same cycle as ovf_clr leaves the flag set.
         tc_d  = bnd;
         ovf_d = (ovf_q & ~ovf_clr) | bnd;
      end
   end

   always_ff @(posedge clk) begin
      if (!sclr_n) begin
         q_q   <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign q   = q_q;
   assign tc  = tc_q;
   assign ovf = ovf_q;

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulo counter, successor to the fixed 20-bit clear-only up-counter. It adds configurable width and terminal value, parallel load, enable, and runtime direction and wrap/saturate mode. It also provides a registered terminal-count pulse and a sticky overflow flag. It serves as the common timing/count primitive for baud generation, timeouts and event counting in the SPART/peripheral datapath.

## Interface
- WIDTH, 20, counter width in bits (1..32)
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL; must be ≤ 2**WIDTH-1

- clk  in  1  rising-edge clock
- sclr_n  in  1  reset, synchronous, active-low
- clr  in  1  synchronous clear of q, tc, ovf (active-high)
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value loaded when load=1
- en  in  1  count enable; one step per cycle while high
- up_dn  in  1  1 = count up, 0 = count down
- sat  in  1  0 = wrap at boundary, 1 = saturate (hold) at boundary
- ovf_clr  in  1  clears ovf only
- q  out  WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered, one cycle)
- ovf  out  1  sticky boundary-crossing flag

## Operation
- Priority each cycle, highest first: sclr_n=0, then clr, then load, then en.
- Reset (sclr_n=0): q=0, tc=0, ovf=0.
- clr: q=0, tc=0, ovf=0. Same effect as reset, but driven as a functional input.
- load: q = min(load_val, MAX_VAL). tc=0. ovf is unchanged. Any concurrent en is ignored.
- en with no load/clr:
  - Up, q<MAX_VAL: q=q+1.
  - Up, q==MAX_VAL: q=0 if sat=0; q holds MAX_VAL if sat=1.
  - Down, q>0: q=q-1.
  - Down, q==0: q=MAX_VAL if sat=0; q holds 0 if sat=1.
- Boundary event: an enabled step taken while q is at the boundary for the current direction (MAX_VAL when up, 0 when down).
  - A boundary event sets tc=1 for the next cycle and sets ovf. This applies in both modes, so in saturate mode tc repeats every cycle while held at the boundary with en=1.
- tc is 0 in every cycle that does not follow a boundary event.
- ovf_clr clears ovf. If ovf_clr and a boundary event occur in the same cycle, set wins and ovf=1.
- en=0: q, and ovf hold; tc=0.
- up_dn and sat are sampled each cycle and may change mid-count. They take effect on the next step with no glitch.
- All arithmetic is done at WIDTH+1 bits internally; no X or out-of-range value is ever driven on q.

## Timing
- All outputs are registered; the only combinational paths are input → next-state logic.
- Latency: an input sampled at edge N is reflected on q/tc/ovf after edge N.
- Step-to-tc: the boundary step at edge N gives tc high during cycle N..N+1. It coincides with the first cycle q shows the wrapped (or held) value.
- Reset mid-count takes effect at the next edge regardless of other inputs. Counting resumes on the first edge with sclr_n=1.
- Throughput: one step per clock; no handshake and no back-pressure.

## Structure
- Shared package peripheral_pkg holds:
  - localparam encodings DIR_UP=1'b1, DIR_DN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1
  - a helper function clamp(val, max) used by load
- Single flat module, with no sub-module needed. Next-state logic goes in one combinational block; state (q, tc, ovf) goes in one sequential block.
- Elaboration-time check: MAX_VAL ≤ 2**WIDTH-1 and WIDTH in 1..32; otherwise a fatal error.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9 unless stated.
- Reset: hold sclr_n=0 with en=1, load=1 for 3 cycles → q=0, tc=0, ovf=0 every cycle. Release → q=1 one edge later (up, en=1).
- Wrap up: from q=0, en=1, up_dn=1, sat=0 for 12 cycles → q goes 1..9,0,1,2. tc is high only in the cycle q=0. ovf=1 from that cycle on.
- Saturate down: load 2, then up_dn=0, sat=1, en=1 for 5 cycles → q goes 1,0,0,0,0. tc is high in each of the last three cycles. ovf=1.
- Load clamp and priority:
  - load_val=15 with en=1 → q=9, tc=0.
  - Next cycle clr=1, load=1 → q=0, ovf=0.
- ovf_clr race: at q=9 up, en=1, ovf_clr=1 in the same cycle → ovf=1. Next cycle ovf_clr=1, en=0 → ovf=0.
- Default parameters (WIDTH=20): load 20'hFFFFE, count up 3 steps → q goes FFFFF, 00000, 00001. tc is high one cycle at q=00000.
